// File: rtl/cipher_out_serializer.sv
// ---------------------------------------------------------------------------
// cipher_out_serializer
//
// Purpose:
//   Holds one ciphertext block from the keystream/plaintext adder and streams
//   it out one element per valid/ready handshake. The adder signals completion
//   with a single-cycle pulse, but the processor reading the bus may stall
//   between reads. This block absorbs that difference.
//
// Ports:
//   Clk_CI          rising-edge clock
//   Rst_RI          asynchronous active-high reset
//   Load_SI         capture strobe (adder finish pulse)
//   InData_CTXT_DI  PASTA_S elements of BITLEN bits; element i at [i*BITLEN +: BITLEN]
//   OutData_DO      current element, zero-extended to OUT_W (0 when not valid)
//   Valid_SO        OutData_DO holds a valid element
//   Ready_SI        consumer accepts the element this cycle
//   Last_SO         current element is index PASTA_S-1
//   Busy_SO         a block is held or streaming
//   Done_SO         one-cycle pulse after the last element is accepted
//   Overrun_SO      sticky: a Load_SI was dropped while streaming
//   Clear_SI        synchronous clear of the sticky flags
//   RangeErr_SO     sticky: a captured element was >= MODULUS
//
// Configuration:
//   CIPHER_OUT_RANGE_CHECK_EN  when defined, every element is compared
//                              against MODULUS at capture. When undefined,
//                              no comparators are built and RangeErr_SO is 0.
// ---------------------------------------------------------------------------
module cipher_out_serializer #(
  parameter int PASTA_S = 32,
  parameter int BITLEN  = 17,
  parameter int OUT_W   = 32,
  parameter int MODULUS = 65537
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        Load_SI,
  input  logic [PASTA_S*BITLEN-1:0]   InData_CTXT_DI,
  output logic [OUT_W-1:0]            OutData_DO,
  output logic                        Valid_SO,
  input  logic                        Ready_SI,
  output logic                        Last_SO,
  output logic                        Busy_SO,
  output logic                        Done_SO,
  output logic                        Overrun_SO,
  input  logic                        Clear_SI,
  output logic                        RangeErr_SO
);

  localparam int CNT_W = (PASTA_S > 1) ? $clog2(PASTA_S) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PASTA_S - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [PASTA_S*BITLEN-1:0]   data_q, data_d;
  logic                        overrun_q, overrun_d;

  logic                        capture;
  logic                        is_last;
  logic [BITLEN-1:0]           cur_elem;

  // True when an element is at or above the field prime. Only instantiated
  // in hardware when the range check is enabled.
  function automatic logic elem_out_of_range(input logic [BITLEN-1:0] e);
    logic [31:0] ext;
    ext = 32'(e);
    return ext >= 32'(MODULUS);
  endfunction

  // A strobe is accepted only when no block is streaming; DONE counts as free
  // so back-to-back blocks need no idle cycle.
  always_comb begin
    capture   = Load_SI && (state_q != STREAM);
    is_last   = (cnt_q == LAST_IDX);

    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (Load_SI) state_d = STREAM;
      end
      STREAM: begin
        if (Ready_SI) begin
          if (is_last) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = Load_SI ? STREAM : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      data_d = InData_CTXT_DI;
      cnt_d  = '0;
    end

    // Set is applied after clear so a simultaneous drop is never lost.
    if (Clear_SI) overrun_d = 1'b0;
    if (Load_SI && (state_q == STREAM)) overrun_d = 1'b1;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  // All outputs come straight from registered state, so the consumer sees no
  // combinational path from Ready_SI or Load_SI.
  always_comb begin
    cur_elem   = data_q[cnt_q*BITLEN +: BITLEN];
    OutData_DO = '0;
    if (state_q == STREAM) OutData_DO[BITLEN-1:0] = cur_elem;
  end

  assign Valid_SO   = (state_q == STREAM);
  assign Last_SO    = (state_q == STREAM) && is_last;
  assign Busy_SO    = (state_q == STREAM);
  assign Done_SO    = (state_q == DONE);
  assign Overrun_SO = overrun_q;

`ifdef CIPHER_OUT_RANGE_CHECK_EN
  logic range_hit;
  logic range_err_q, range_err_d;

  // All elements are checked in parallel on the incoming vector so the flag
  // rises on the capture edge itself.
  always_comb begin
    range_hit = 1'b0;
    for (int i = 0; i < PASTA_S; i++) begin
      if (elem_out_of_range(InData_CTXT_DI[i*BITLEN +: BITLEN])) range_hit = 1'b1;
    end
    range_err_d = range_err_q;
    if (Clear_SI) range_err_d = 1'b0;
    if (capture && range_hit) range_err_d = 1'b1;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign RangeErr_SO = range_err_q;
`else
  assign RangeErr_SO = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_cipher_out_serializer
//
// Purpose:
//   Self-checking bench for cipher_out_serializer. Per-cycle vectors hold the
//   inputs for a cycle and the outputs expected during that cycle (before the
//   next rising edge). Multi-cycle corner cases (async reset mid-stream, load
//   during the Done cycle, range check) are written out by hand.
//
// Configuration:
//   CIPHER_OUT_RANGE_CHECK_EN  selects the expected RangeErr_SO behaviour.
// ---------------------------------------------------------------------------
module tb_cipher_out_serializer;

  localparam int PASTA_S = 32;
  localparam int BITLEN  = 17;
  localparam int OUT_W   = 32;

`ifdef CIPHER_OUT_RANGE_CHECK_EN
  localparam logic RC_EN = 1'b1;
`else
  localparam logic RC_EN = 1'b0;
`endif

  logic                      clk;
  logic                      rst;
  logic                      load;
  logic [PASTA_S*BITLEN-1:0] in_data;
  logic [OUT_W-1:0]          out_data;
  logic                      valid;
  logic                      ready;
  logic                      last;
  logic                      busy;
  logic                      done;
  logic                      overrun;
  logic                      clear;
  logic                      range_err;

  int errors = 0;
  int checks = 0;

  cipher_out_serializer #(
    .PASTA_S(PASTA_S),
    .BITLEN (BITLEN),
    .OUT_W  (OUT_W),
    .MODULUS(65537)
  ) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Load_SI       (load),
    .InData_CTXT_DI(in_data),
    .OutData_DO    (out_data),
    .Valid_SO      (valid),
    .Ready_SI      (ready),
    .Last_SO       (last),
    .Busy_SO       (busy),
    .Done_SO       (done),
    .Overrun_SO    (overrun),
    .Clear_SI      (clear),
    .RangeErr_SO   (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running clock guarantees progress; this only guards against a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        load;
    logic        ready;
    logic        clear;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
    logic        ovr;
    logic        rng;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [37:0] pack_exp(vec_t v);
    return {v.data, v.valid, v.last, v.busy, v.done, v.ovr, v.rng};
  endfunction

  function automatic logic [37:0] pack_act();
    return {out_data, valid, last, busy, done, overrun, range_err};
  endfunction

  function automatic logic [37:0] mk(logic [31:0] d, logic v, logic l, logic b,
                                     logic dn, logic o, logic r);
    return {d, v, l, b, dn, o, r};
  endfunction

  task automatic check_output(string name, logic [37:0] act, logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got data=%h v%b l%b b%b d%b o%b r%b, expected data=%h v%b l%b b%b d%b o%b r%b",
               name, act[37:6], act[5], act[4], act[3], act[2], act[1], act[0],
               exp[37:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(logic ld, logic rd, logic cl, logic [31:0] d, logic v,
                      logic l, logic b, logic dn, logic o, logic r);
    vec_t t;
    t.load = ld; t.ready = rd; t.clear = cl; t.data = d; t.valid = v;
    t.last = l; t.busy = b; t.done = dn; t.ovr = o; t.rng = r;
    vecs.push_back(t);
  endtask

  // At each falling edge: check the outputs of the current cycle, then drive
  // that cycle's inputs for the next rising edge.
  task automatic apply_stimulus(string name);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_output($sformatf("%s[%0d]", name, i), pack_act(), pack_exp(vecs[i]));
      load  = vecs[i].load;
      ready = vecs[i].ready;
      clear = vecs[i].clear;
    end
    vecs.delete();
  endtask

  task automatic set_data_incr();
    for (int i = 0; i < PASTA_S; i++) in_data[i*BITLEN +: BITLEN] = BITLEN'(i + 1);
  endtask

  task automatic set_data_const(logic [BITLEN-1:0] val);
    for (int i = 0; i < PASTA_S; i++) in_data[i*BITLEN +: BITLEN] = val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    load = 1'b0; ready = 1'b0; clear = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; ready = 1'b0; clear = 1'b0;
    in_data = '0;
    #1;
    check_output("reset_state", pack_act(), mk(32'h0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Full-rate stream: 32 elements on 32 consecutive cycles.
    set_data_incr();
    push(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= PASTA_S; v++)
      push(0, 1, 0, 32'(v), 1, (v == PASTA_S), 1, 0, 0, 0);
    push(0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 0);
    push(0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("full_rate");

    // Ready toggling 0,1: each element held one stall cycle, 64 cycles total.
    push(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int e = 0; e < PASTA_S; e++) begin
      push(0, 0, 0, 32'(e + 1), 1, (e == PASTA_S - 1), 1, 0, 0, 0);
      push(0, 1, 0, 32'(e + 1), 1, (e == PASTA_S - 1), 1, 0, 0, 0);
    end
    push(0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0);
    push(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("stall");

    // Load dropped at element 10: stream continues from the original data,
    // Overrun_SO stays set until cleared.
    push(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 9; v++) push(0, 1, 0, 32'(v), 1, 0, 1, 0, 0, 0);
    push(1, 1, 0, 32'd10, 1, 0, 1, 0, 0, 0);
    for (int v = 11; v <= PASTA_S; v++)
      push(0, 1, 0, 32'(v), 1, (v == PASTA_S), 1, 0, 1, 0);
    push(0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0);
    push(0, 0, 1, 32'h0, 0, 0, 0, 0, 1, 0);
    push(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("overrun");

    // Async reset while element 5 is presented.
    push(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 4; v++) push(0, 1, 0, 32'(v), 1, 0, 1, 0, 0, 0);
    apply_stimulus("pre_reset");
    @(negedge clk);
    check_output("before_reset_elem5", pack_act(), mk(32'd5, 1, 0, 1, 0, 0, 0));
    rst = 1'b1;
    #1;
    check_output("reset_immediate", pack_act(), mk(32'h0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("post_reset_quiet[%0d]", i), pack_act(),
                   mk(32'h0, 0, 0, 0, 0, 0, 0));
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ready = 1'b0;
    check_output("restart_elem0", pack_act(), mk(32'd1, 1, 0, 1, 0, 0, 0));
    do_reset();

    // New capture during the Done cycle goes straight back to streaming.
    set_data_incr();
    push(1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= PASTA_S; v++)
      push(0, 1, 0, 32'(v), 1, (v == PASTA_S), 1, 0, 0, 0);
    apply_stimulus("pre_done_load");
    @(negedge clk);
    check_output("done_cycle_load", pack_act(), mk(32'h0, 0, 0, 0, 1, 0, 0));
    set_data_const(17'h1FFFF);
    load = 1'b1;
    ready = 1'b1;
    for (int e = 0; e < PASTA_S; e++) begin
      @(negedge clk);
      load = 1'b0;
      check_output($sformatf("back_to_back[%0d]", e), pack_act(),
                   mk(32'h0001FFFF, 1, (e == PASTA_S - 1), 1, 0, 0, RC_EN));
    end
    @(negedge clk);
    check_output("back_to_back_done", pack_act(), mk(32'h0, 0, 0, 0, 1, 0, RC_EN));
    do_reset();

    // Range check: element 7 at MODULUS trips the flag, one below does not.
    set_data_incr();
    in_data[7*BITLEN +: BITLEN] = 17'h10001;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_output("range_at_modulus", pack_act(), mk(32'd1, 1, 0, 1, 0, 0, RC_EN));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_output("range_cleared", pack_act(), mk(32'd1, 1, 0, 1, 0, 0, 0));
    do_reset();
    in_data[7*BITLEN +: BITLEN] = 17'h10000;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_output("range_below_modulus", pack_act(), mk(32'd1, 1, 0, 1, 0, 0, 0));
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cipher_out_serializer.md
Name: cipher_out_serializer

Overview:
- Downstream stage of the keystream/plaintext addition block.
- Captures the 32x17-bit ciphertext vector on the adder's one-cycle finish pulse.
- Streams it out one element per handshake over a 32-bit valid/ready bus toward the RISC-V load/store interface.
- Decouples the single-cycle result pulse from a processor that may stall between reads.

Parameters:
PASTA_S, 32, number of ciphertext elements per block
BITLEN, 17, bits per element
OUT_W, 32, output bus width (must be >= BITLEN)
MODULUS, 65537, field prime p used by the optional range check

Ports:
Clk_CI  input  1  rising-edge clock
Rst_RI  input  1  asynchronous active-high reset
Load_SI  input  1  capture strobe (the adder's finish pulse)
InData_CTXT_DI  input  PASTA_S*BITLEN  ciphertext vector; element i is bits [i*BITLEN +: BITLEN]
OutData_DO  output  OUT_W  current element, zero-extended
Valid_SO  output  1  OutData_DO holds a valid element
Ready_SI  input  1  consumer accepts the element this cycle
Last_SO  output  1  current element is index PASTA_S-1
Busy_SO  output  1  a block is held or streaming
Done_SO  output  1  one-cycle pulse after the last element is accepted
Overrun_SO  output  1  sticky: a Load_SI was dropped while busy
Clear_SI  input  1  synchronous clear of the sticky flags
RangeErr_SO  output  1  sticky range-check flag (optional feature)

Behaviour:
- Reset (asynchronous, Rst_RI=1):
  - State IDLE, element counter 0, capture register 0.
  - All outputs 0: OutData_DO, Valid_SO, Last_SO, Busy_SO, Done_SO, Overrun_SO, RangeErr_SO.
  - Reset asserted mid-stream aborts the block; no Done_SO is issued.
- State machine: IDLE, STREAM, DONE.
- IDLE:
  - Load_SI=1 at edge n: the vector is captured, counter=0, state becomes STREAM.
  - From edge n, Valid_SO=1, Busy_SO=1 and OutData_DO = element 0 (one-cycle latency from strobe to first element).
- STREAM:
  - OutData_DO = {zeros, element[counter]}; Valid_SO=1; Last_SO = (counter == PASTA_S-1).
  - A handshake occurs on an edge where Valid_SO & Ready_SI.
  - On handshake, counter increments.
  - On the handshake of element PASTA_S-1: state becomes DONE, Valid_SO=0, Last_SO=0, counter wraps to 0.
  - Ready_SI low: output holds stable, with no change to data, Valid_SO or counter.
- DONE:
  - Done_SO=1 for exactly one cycle; Busy_SO=0; state becomes IDLE on the next edge.
  - A Load_SI seen during DONE is accepted as a new capture (DONE to STREAM directly); Done_SO still pulses in that cycle.
- Load_SI while in STREAM:
  - The strobe is dropped; the captured data and counter are unchanged.
  - Overrun_SO is set and stays set until Clear_SI.
- Clear_SI:
  - Clears Overrun_SO and RangeErr_SO next edge.
  - If a set event and Clear_SI occur in the same cycle, set wins.
- Ready_SI while Valid_SO=0 has no effect.
- OutData_DO is 0 whenever Valid_SO=0.
- Throughput: PASTA_S elements in PASTA_S cycles with Ready_SI held high. IDLE-to-IDLE takes PASTA_S+1 cycles plus stalls.

Optional Feature:
- Macro: CIPHER_OUT_RANGE_CHECK_EN.
- Defined:
  - At capture, each element is compared to MODULUS in parallel.
  - If any element is >= MODULUS, RangeErr_SO is set (sticky) on the capture edge.
  - The data still streams unmodified.
- Undefined:
  - No comparators are built.
  - RangeErr_SO is tied 0.

Test Plan:
- Reset then Load_SI with element i = i+1, Ready_SI=1 -> OutData_DO = 0x00000001..0x00000020 on 32 consecutive cycles; Last_SO only with 0x20; Done_SO one cycle later; Busy_SO low after.
- Same load, Ready_SI toggled 1,0,1,0 -> each element held while Ready_SI=0; order and values unchanged; 64 cycles to completion.
- Load_SI again at element 10 of an active stream -> Overrun_SO=1, stream continues 11..32 from the original data; Clear_SI -> Overrun_SO=0.
- Rst_RI pulsed at element 5 -> all outputs 0 immediately; no Done_SO; a following Load_SI restarts at element 0.
- Load_SI in the Done_SO cycle with new data 0x1FFFF in every element -> Done_SO pulses, next cycle Valid_SO=1 with OutData_DO=0x0001FFFF.
- CIPHER_OUT_RANGE_CHECK_EN defined, element 7 = 0x10001 (=MODULUS) -> RangeErr_SO=1 after capture; with element 7 = 0x10000 -> stays 0; macro undefined -> always 0.
